mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/mem_arb_sel.sv | 27 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// requester port indices and the full-word byte-enable constant.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic       PORT_IF = 1'b0;
  localparam logic       PORT_LS = 1'b1;
  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational 2-way winner select. Fixed priority gives load/store the
// win on contention; with rr_en set, contention goes to the port that was
// not granted most recently.
module mem_arb_sel
  import rv32i_pkg::*;
#(
  parameter bit rr_en = 1'b0
) (
  input  logic if_req,
  input  logic ls_req,
  input  logic last_owner,
  output logic any_req,
  output logic winner
);

  // Pick a single winner; only meaningful while any_req is high.
  always_comb begin
    any_req = if_req | ls_req;
    winner  = PORT_IF;
    if (if_req && ls_req) begin
      winner = rr_en ? ~last_owner : PORT_LS;
    end else if (ls_req) begin
      winner = PORT_LS;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (port 0, read-only) and
// load/store (port 1) share one memory port. One transaction in flight:
// IDLE grants, ACCESS drives memory until mem_ready, RESP pulses rvalid.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise load/store has fixed priority.
module mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [width-1:0] if_addr,
  input  logic             ls_req,
  input  logic [width-1:0] ls_addr,
  input  logic             ls_we,
  input  logic [width-1:0] ls_wdata,
  input  logic [3:0]       ls_be,
  output logic             if_gnt,
  output logic             ls_gnt,
  output logic             if_rvalid,
  output logic             ls_rvalid,
  output logic [width-1:0] rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_ready
);

  arb_state_t       state, state_next;
  logic             any_req, winner;
  logic             owner;
  logic             sel_last;
  logic             lat_we;
  logic [width-1:0] lat_addr, lat_wdata;
  logic [3:0]       lat_be;

`ifdef MEM_ARB_RR_EN
  // The transaction owner flop doubles as the last-granted record.
  assign sel_last = owner;
  localparam bit RR = 1'b1;
`else
  assign sel_last = PORT_IF;
  localparam bit RR = 1'b0;
`endif

  mem_arb_sel #(.rr_en(RR)) u_sel (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .last_owner (sel_last),
    .any_req    (any_req),
    .winner     (winner)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    ls_rvalid  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          if_gnt     = (winner == PORT_IF);
          ls_gnt     = (winner == PORT_LS);
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        if (mem_ready) state_next = ST_RESP;
      end
      ST_RESP: begin
        if_rvalid  = (owner == PORT_IF);
        ls_rvalid  = (owner == PORT_LS);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the winning request at grant and capture read data on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= PORT_IF;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rdata     <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        owner <= winner;
        if (winner == PORT_LS) begin
          lat_we    <= ls_we;
          lat_addr  <= ls_addr;
          lat_wdata <= ls_wdata;
          lat_be    <= ls_be;
        end else begin
          lat_we    <= 1'b0;
          lat_addr  <= if_addr;
          lat_wdata <= '0;
          lat_be    <= BE_FULL;
        end
      end
      if (state == ST_ACCESS && mem_ready) rdata <= mem_rdata;
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_be    = lat_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter.
module tb_mem_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ready = 1'b0;
  logic [W-1:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic [3:0]   ls_be = '0;
  logic         if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we;
  logic [W-1:0] rdata, mem_addr, mem_wdata;
  logic [3:0]   mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.width(W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .if_gnt(if_gnt), .ls_gnt(ls_gnt), .if_rvalid(if_rvalid), .ls_rvalid(ls_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         req_if, req_ls;
    logic [31:0]  a_if, a_ls;
    logic         we;
    logic [31:0]  wdata;
    logic [3:0]   be;
    int           waits;
    logic [31:0]  rd;
    logic         exp_owner;
    logic [31:0]  exp_addr;
    logic         exp_we;
    logic [3:0]   exp_be;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    step();
    if_req = v.req_if; ls_req = v.req_ls;
    if_addr = v.a_if;  ls_addr = v.a_ls;
    ls_we = v.we; ls_wdata = v.wdata; ls_be = v.be;
    mem_ready = 1'b0;
    #2;
    check("gnt_if", if_gnt, v.exp_owner == 1'b0);
    check("gnt_ls", ls_gnt, v.exp_owner == 1'b1);
    check("en_idle", mem_en, 0);
    for (int k = 0; k <= v.waits; k++) begin
      step();
      if_req = 1'b0; ls_req = 1'b0;
      mem_ready = (k == v.waits);
      mem_rdata = (k == v.waits) ? v.rd : (32'hFFFF0000 | k);
      #2;
      check("acc_en", mem_en, 1);
      check("acc_addr", mem_addr, v.exp_addr);
      check("acc_we", mem_we, v.exp_we);
      check("acc_be", mem_be, v.exp_be);
      if (v.exp_we) check("acc_wdata", mem_wdata, v.wdata);
      check("acc_gnt", {if_gnt, ls_gnt}, 0);
      check("acc_rvalid", {if_rvalid, ls_rvalid}, 0);
    end
    step();
    mem_ready = 1'b0;
    #2;
    check("resp_en", mem_en, 0);
    check("resp_rv_if", if_rvalid, v.exp_owner == 1'b0);
    check("resp_rv_ls", ls_rvalid, v.exp_owner == 1'b1);
    if (!v.exp_we) check("resp_rdata", rdata, v.rd);
    step();
    #2;
    check("idle_rvalid", {if_rvalid, ls_rvalid}, 0);
    if (!v.exp_we) check("rdata_hold", rdata, v.rd);
  endtask

  logic exp_seq[4];
  logic got_seq[4];
  int   n_got;
  logic pend_if, pend_ls, drop_if, drop_ls;
  int   outstanding;
  logic gnt_port;
  logic prev_hold;
  logic [W-1:0] p_addr, p_wdata;
  logic [3:0]   p_be;
  logic         p_we;

  initial begin
    // REQ-028 read, REQ-029 store with 3 wait states, and contention cases.
    vecs[0] = '{1,0, 32'h100, 0, 0, 0, 4'h0, 0, 32'h12345678, 0, 32'h100, 0, 4'hF};
    vecs[1] = '{0,1, 0, 32'h2004, 1, 32'hDEADBEEF, 4'b0011, 3, 0, 1, 32'h2004, 1, 4'b0011};
    vecs[2] = '{0,1, 0, 32'h3000, 0, 32'h0, 4'hF, 1, 32'hCAFEF00D, 1, 32'h3000, 0, 4'hF};
    vecs[3] = '{1,0, 32'h104, 32'h9999, 1, 32'h55, 4'b0001, 2, 32'hA5A5A5A5, 0, 32'h104, 0, 4'hF};
    vecs[4] = '{1,1, 32'h200, 32'h400, 0, 0, 4'b1100, 0, 32'h0BADCAFE, 1, 32'h400, 0, 4'b1100};
`ifdef MEM_ARB_RR_EN
    vecs[5] = '{1,1, 32'h200, 32'h404, 1, 32'h77, 4'b1000, 1, 32'h13572468, 0, 32'h200, 0, 4'hF};
`else
    vecs[5] = '{1,1, 32'h200, 32'h404, 1, 32'h77, 4'b1000, 1, 32'h13572468, 1, 32'h404, 1, 4'b1000};
`endif
    vecs[6] = '{1,0, 32'h300, 0, 0, 0, 4'b0000, 0, 32'h89ABCDEF, 0, 32'h300, 0, 4'hF};

    // Reset state.
    #3;
    check("rst_gnt", {if_gnt, ls_gnt}, 0);
    check("rst_rvalid", {if_rvalid, ls_rvalid}, 0);
    check("rst_en_we", {mem_en, mem_we}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    check("rst_rdata", rdata, 0);
    step();
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requests held: four grants, pattern depends on arbitration mode.
    // Last owner after vecs[6] is IF, so round robin starts with LS.
`ifdef MEM_ARB_RR_EN
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    n_got = 0;
    step();
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h1000; ls_addr = 32'h2000; ls_we = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 40 && n_got < 4; c++) begin
      #2;
      check("dual_gnt_hold", if_gnt & ls_gnt, 0);
      if (if_gnt || ls_gnt) begin
        got_seq[n_got] = ls_gnt;
        n_got++;
      end
      step();
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("contention_count", n_got, 4);
    for (int i = 0; i < 4; i++) check("contention_order", got_seq[i], exp_seq[i]);
    repeat (3) step();

    // Reset asserted mid-ACCESS.
    ls_req = 1'b1; ls_addr = 32'h5000; ls_we = 1'b0; mem_ready = 1'b0;
    #2;
    check("rst_mid_gnt", ls_gnt, 1);
    step();
    ls_req = 1'b0;
    #2;
    check("rst_mid_en_before", mem_en, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_en", mem_en, 0);
    check("rst_mid_addr", mem_addr, 0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("rst_mid_no_rvalid", {if_rvalid, ls_rvalid, mem_en}, 0);
      step();
    end
    if_req = 1'b1; if_addr = 32'h700; mem_rdata = 32'h31415926;
    #2;
    check("post_rst_gnt", {if_gnt, ls_gnt}, 2'b10);
    step();
    if_req = 1'b0;
    #2;
    check("post_rst_addr", mem_addr, 32'h700);
    check("post_rst_en", mem_en, 1);
    step();
    #2;
    check("post_rst_rvalid", if_rvalid, 1);
    check("post_rst_rdata", rdata, 32'h31415926);
    step();

    // Randomized traffic with protocol checks.
    pend_if = 0; pend_ls = 0; drop_if = 0; drop_ls = 0;
    outstanding = 0; gnt_port = 0; prev_hold = 0;
    if_addr = 32'h40; ls_addr = 32'h80;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (drop_if) begin if_req = 1'b0; pend_if = 0; drop_if = 0; end
      if (drop_ls) begin ls_req = 1'b0; pend_ls = 0; drop_ls = 0; end
      if (!pend_if && $urandom_range(0, 3) == 0) begin
        pend_if = 1; if_req = 1'b1; if_addr = $urandom;
      end
      if (!pend_ls && $urandom_range(0, 3) == 0) begin
        pend_ls = 1; ls_req = 1'b1; ls_addr = $urandom; ls_we = $urandom_range(0, 1) == 1;
        ls_wdata = $urandom; ls_be = 4'($urandom_range(0, 15));
      end
      mem_ready = $urandom_range(0, 2) != 0;
      mem_rdata = $urandom;
      #2;
      check("rnd_dual_gnt", if_gnt & ls_gnt, 0);
      check("rnd_dual_rvalid", if_rvalid & ls_rvalid, 0);
      if (if_gnt || ls_gnt) begin
        check("rnd_gnt_outstanding", outstanding, 0);
        outstanding = 1;
        gnt_port = ls_gnt;
        if (if_gnt) drop_if = 1;
        if (ls_gnt) drop_ls = 1;
      end
      if (if_rvalid || ls_rvalid) begin
        check("rnd_rvalid_outstanding", outstanding, 1);
        check("rnd_rvalid_port", ls_rvalid, gnt_port);
        outstanding = 0;
      end
      if (prev_hold) begin
        check("rnd_stable", {mem_en, mem_we, mem_addr, mem_wdata[26:0], mem_be},
              {1'b1, p_we, p_addr, p_wdata[26:0], p_be});
      end
      prev_hold = mem_en && !mem_ready;
      p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
